// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle control unit.
package cpu_pkg;

    localparam int unsigned STATE_W             = 3;
    localparam int unsigned RETIRED_W           = 32;
    localparam int unsigned TIMEOUT_CNT_W       = 8;
    localparam int unsigned MEM_TIMEOUT_DEFAULT = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALT      = 3'd4,
        ST_ERROR     = 3'd5,
        ST_STEP_WAIT = 3'd6
    } ctrl_state_t;

    // State-decoded control strobes (everything except ir_load).
    typedef struct packed {
        logic imem_req;
        logic alu_en;
        logic reg_we;
        logic pc_en;
        logic halted;
        logic error;
    } ctrl_out_t;

    function automatic ctrl_out_t decode_outputs(input ctrl_state_t st);
        ctrl_out_t o;
        o = '0;
        case (st)
            ST_FETCH:     o.imem_req = 1'b1;
            ST_EXECUTE:   o.alu_en   = 1'b1;
            ST_WRITEBACK: begin
                o.reg_we = 1'b1;
                o.pc_en  = 1'b1;
            end
            ST_HALT:      o.halted   = 1'b1;
            ST_ERROR:     o.error    = 1'b1;
            default:      o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mem_timeout.sv
// Fetch wait counter; flags when LIMIT-1 cycles have elapsed without an ack.
module mem_timeout
    import cpu_pkg::*;
#(
    parameter int unsigned LIMIT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired_c
);

    logic [TIMEOUT_CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (count_en) begin
            count_q <= count_q + TIMEOUT_CNT_W'(1);
        end
    end

    assign expired_c = (count_q == TIMEOUT_CNT_W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXECUTE/WRITEBACK with HALT and ERROR.
// Optional single-step operation is selected with the SINGLE_STEP_EN macro.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_ack,
    input  logic                 is_halt,
    input  logic                 step,
    output logic                 imem_req,
    output logic                 ir_load,
    output logic                 alu_en,
    output logic                 reg_we,
    output logic                 pc_en,
    output logic                 halted,
    output logic                 error,
    output logic [STATE_W-1:0]   state,
    output logic [RETIRED_W-1:0] retired
);

`ifdef SINGLE_STEP_EN
    localparam ctrl_state_t IDLE_STATE = ST_STEP_WAIT;
`else
    localparam ctrl_state_t IDLE_STATE = ST_FETCH;
    logic unused_step;
    assign unused_step = step;
`endif

    ctrl_state_t          state_q;
    ctrl_state_t          state_d;
    ctrl_out_t            moore_c;
    logic [RETIRED_W-1:0] retired_q;
    logic                 fetch_c;
    logic                 timeout_c;

    assign fetch_c = (state_q == ST_FETCH);

    // Counter is held clear outside FETCH, so it restarts at zero on every entry.
    mem_timeout #(
        .LIMIT (MEM_TIMEOUT)
    ) u_mem_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear     (!fetch_c || imem_ack),
        .count_en  (fetch_c && !imem_ack),
        .expired_c (timeout_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        moore_c = decode_outputs(state_q);
        case (state_q)
            ST_FETCH: begin
                // Ack in the timeout cycle still completes the fetch.
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (timeout_c) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE:    state_d = is_halt ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = IDLE_STATE;
            ST_HALT:      state_d = ST_HALT;
            ST_ERROR:     state_d = ST_ERROR;
`ifdef SINGLE_STEP_EN
            ST_STEP_WAIT: state_d = step ? ST_FETCH : ST_STEP_WAIT;
`else
            ST_STEP_WAIT: state_d = ST_ERROR;
`endif
            default:      state_d = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else if (state_q == ST_WRITEBACK) begin
            retired_q <= retired_q + RETIRED_W'(1);
        end
    end

    assign imem_req = moore_c.imem_req;
    assign ir_load  = fetch_c && imem_ack;
    assign alu_en   = moore_c.alu_en;
    assign reg_we   = moore_c.reg_we;
    assign pc_en    = moore_c.pc_en;
    assign halted   = moore_c.halted;
    assign error    = moore_c.error;
    assign state    = state_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus schedules instructions and predicts writebacks.
module tb_multicycle_ctrl;
    import cpu_pkg::*;

    localparam int unsigned MT = 16;
`ifdef SINGLE_STEP_EN
    localparam logic [31:0] IDLE_ST = 32'd6;
`else
    localparam logic [31:0] IDLE_ST = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ack;
    logic        is_halt;
    logic        step;
    logic        imem_req;
    logic        ir_load;
    logic        alu_en;
    logic        reg_we;
    logic        pc_en;
    logic        halted;
    logic        error;
    logic [2:0]  state;
    logic [31:0] retired;

    multicycle_ctrl #(
        .MEM_TIMEOUT (MT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .imem_ack (imem_ack),
        .is_halt  (is_halt),
        .step     (step),
        .imem_req (imem_req),
        .ir_load  (ir_load),
        .alu_en   (alu_en),
        .reg_we   (reg_we),
        .pc_en    (pc_en),
        .halted   (halted),
        .error    (error),
        .state    (state),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [31:0] ret;
    } wb_exp_t;

    wb_exp_t     sb_q[$];
    wb_exp_t     mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] n_ret;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    // Inputs apply to the current cycle; advance to 1ns after the next rising edge.
    task automatic drive(input logic a, input logic h, input logic st);
        imem_ack = a;
        is_halt  = h;
        step     = st;
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        #3;
    endtask

    // Writeback monitor: every reg_we must match the oldest predicted retirement.
    always @(negedge clk) begin
        if (reg_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_reg_we", 32'(reg_we), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("wb_cycle", cyc, mon_e.cyc);
                check("wb_retired", retired, mon_e.ret);
            end
            check("pc_en_with_reg_we", 32'(pc_en), 32'd1);
        end else if (pc_en === 1'b1) begin
            check("stray_pc_en", 32'(pc_en), 32'd0);
        end
        if ((ir_load | alu_en | reg_we) === 1'b1)
            check("enable_onehot", 32'(ir_load) + 32'(alu_en) + 32'(reg_we), 32'd1);
    end

    task automatic begin_instr();
`ifdef SINGLE_STEP_EN
        int g;
        g = int'($urandom_range(3, 0));
        for (int i = 0; i < g; i++) drive(rb(), rb(), 1'b0);
        drive(rb(), rb(), 1'b1);
`endif
    endtask

    // One non-halting instruction whose ack arrives d cycles into FETCH.
    task automatic run_instr(input int d);
        begin_instr();
        sb_q.push_back('{cyc: cyc + 32'(d) + 3, ret: n_ret});
        n_ret++;
        for (int i = 0; i < d; i++) drive(1'b0, rb(), rb());
        drive(1'b1, rb(), rb());
        drive(rb(), 1'b0, rb());
        drive(rb(), rb(), rb());
        drive(rb(), rb(), rb());
    endtask

    task automatic run_halt(input int d);
        begin_instr();
        for (int i = 0; i < d; i++) drive(1'b0, rb(), rb());
        drive(1'b1, rb(), rb());
        drive(rb(), 1'b1, rb());
        peek();
        check("halt_state", 32'(state), 32'd4);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_retired", retired, n_ret);
        for (int i = 0; i < 6; i++) drive(1'b1, rb(), rb());
        peek();
        check("halt_hold_state", 32'(state), 32'd4);
        check("halt_hold_retired", retired, n_ret);
        check("halt_no_req", 32'(imem_req), 32'd0);
    endtask

    task automatic run_timeout();
        begin_instr();
        for (int i = 0; i < int'(MT); i++) begin
            if (i == int'(MT) - 1) begin
                peek();
                check("pre_timeout_state", 32'(state), 32'd0);
                check("pre_timeout_error", 32'(error), 32'd0);
            end
            drive(1'b0, rb(), rb());
        end
        peek();
        check("timeout_state", 32'(state), 32'd5);
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_no_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 6; i++) drive(1'b1, rb(), rb());
        peek();
        check("error_hold_state", 32'(state), 32'd5);
        check("error_hold_retired", retired, n_ret);
    endtask

    task automatic run_reset_in_execute();
        begin_instr();
        drive(1'b1, 1'b0, rb());
        drive(rb(), 1'b0, rb());
        peek();
        check("mid_exec_state", 32'(state), 32'd2);
        check("mid_exec_alu_en", 32'(alu_en), 32'd1);
        rst = 1'b1;
        drive(rb(), rb(), rb());
        rst = 1'b0;
        n_ret = 0;
        peek();
        check("post_rst_state", 32'(state), IDLE_ST);
        check("post_rst_retired", retired, 32'd0);
        check("post_rst_reg_we", 32'(reg_we), 32'd0);
    endtask

    task automatic do_reset(input bit check_drain);
        if (check_drain) check("sb_drained", 32'(sb_q.size()), 32'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        sb_q.delete();
        n_ret = 0;
        peek();
        check("rst_state", 32'(state), IDLE_ST);
        check("rst_retired", retired, 32'd0);
        check("rst_flags", {30'd0, halted, error}, 32'd0);
        check("rst_enables", {28'd0, ir_load, alu_en, reg_we, pc_en}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        imem_ack = 1'b0;
        is_halt = 1'b0;
        step = 1'b0;
        n_ret = 0;
        @(posedge clk);
        #1;
        do_reset(1'b0);

`ifdef SINGLE_STEP_EN
        for (int i = 0; i < 5; i++) drive(1'b1, rb(), 1'b0);
        peek();
        check("no_step_state", 32'(state), 32'd6);
        check("no_step_retired", retired, 32'd0);
`endif

        for (int i = 0; i < 3; i++) run_instr(0);
        peek();
        check("retired_after_3", retired, 32'd3);
        check("idle_after_3", 32'(state), IDLE_ST);

        do_reset(1'b1);
        run_instr(5);
        run_instr(5);
        peek();
        check("slow_mem_retired", retired, 32'd2);
        check("slow_mem_error", 32'(error), 32'd0);

        do_reset(1'b1);
        run_instr(int'(MT) - 1);
        run_instr(0);
        run_timeout();

        do_reset(1'b1);
        run_instr(1);
        run_halt(2);

        do_reset(1'b1);
        run_instr(0);
        run_instr(2);
        run_reset_in_execute();
        run_instr(3);
        peek();
        check("after_mid_rst_retired", retired, n_ret);

        do_reset(1'b1);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(19, 0) == 0) run_instr(int'(MT) - 1);
            else run_instr(int'($urandom_range(6, 0)));
        end
        peek();
        check("random_retired", retired, n_ret);
        run_halt(int'($urandom_range(4, 0)));

        do_reset(1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0);
        check("final_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
